// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller state; encoding is visible on state_o.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMcWait  = 2'd1,
        StMemWait = 2'd2
    } state_e;

    // Operand source selects for the EX-stage forwarding muxes.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

endpackage

// File: rtl/hazard_fwd_mux.sv
// Forwarding compare and 3:1 operand mux for one EX-stage source operand.
module hazard_fwd_mux
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               enable,
    input  logic [RADDR_W-1:0] src,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic               mem_regwrite,
    input  logic               mem_memread,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic               wb_regwrite,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [1:0]         sel,
    output logic [DATA_W-1:0]  operand
);

    logic hit_mem;
    logic hit_wb;

    // A load in MEM has no data yet, so it is never a forwarding source; MEM wins ties.
    always_comb begin
        hit_mem = mem_regwrite && !mem_memread && (mem_waddr != '0) && (mem_waddr == src);
        hit_wb  = wb_regwrite && (wb_waddr != '0) && (wb_waddr == src);
        sel     = FWD_RF;
        if (enable) begin
            if (hit_mem) begin
                sel = FWD_MEM;
            end else if (hit_wb) begin
                sel = FWD_WB;
            end
        end
    end

    // Operand mux driven by the select above.
    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_MEM: operand = mem_data;
            FWD_WB:  operand = wb_data;
            default: operand = rf_data;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline: load-use stall,
// taken-branch flush, data-memory wait, multi-cycle EX ops and perf counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned MC_LAT      = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [RADDR_W-1:0] ex_rs,
    input  logic [RADDR_W-1:0] ex_rt,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic               ex_mc_start,
    input  logic [DATA_W-1:0]  ex_rdA,
    input  logic [DATA_W-1:0]  ex_rdB,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic               mem_regwrite,
    input  logic               mem_memread,
    input  logic [DATA_W-1:0]  mem_alu_out,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic               wb_regwrite,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               branch_taken,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               idex_write,
    output logic               exmem_write,
    output logic               memwb_write,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic               memwb_flush,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [DATA_W-1:0]  ex_opA,
    output logic [DATA_W-1:0]  ex_opB,
    output logic               mc_abort,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               err_timeout
);

    localparam int unsigned MC_W   = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              resume_mc_q, resume_mc_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic freeze;
    logic load_use;
    logic in_mc;
    logic branch_flush;

    // ex_regwrite is carried for interface symmetry; hazards key off ex_memread alone.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    assign freeze   = dmem_req && !dmem_ready;
    assign load_use = ex_memread && (ex_waddr != '0) &&
                      ((id_uses_rs && (ex_waddr == id_rs)) ||
                       (id_uses_rt && (ex_waddr == id_rt)));
    // A memory wait that interrupted a multi-cycle op resumes it once dmem_ready returns.
    assign in_mc    = (state_q == StMcWait) || ((state_q == StMemWait) && resume_mc_q);

    // Next-state, enable and flush decode in priority order.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        memwb_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        mc_abort     = 1'b0;
        branch_flush = 1'b0;
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        resume_mc_d  = resume_mc_q;
        wait_cnt_d   = '0;
        err_d        = err_q;

        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            memwb_flush = 1'b1;
            state_d     = StMemWait;
            resume_mc_d = in_mc;
            wait_cnt_d  = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
                err_d = 1'b1;
            end
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            branch_flush = 1'b1;
            mc_abort     = in_mc;
            mc_cnt_d     = '0;
            resume_mc_d  = 1'b0;
            state_d      = StRun;
        end else if (in_mc) begin
            resume_mc_d = 1'b0;
            if (mc_cnt_q == MC_W'(1)) begin
                mc_cnt_d = '0;
                state_d  = StRun;
            end else begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
                mc_cnt_d    = mc_cnt_q - 1'b1;
                state_d     = StMcWait;
            end
        end else begin
            resume_mc_d = 1'b0;
            state_d     = StRun;
            // The start cycle itself is the first of MC_LAT EX cycles.
            if (ex_mc_start && (MC_LAT > 1)) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
                mc_cnt_d    = MC_W'(MC_LAT - 1);
                state_d     = StMcWait;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // State, multi-cycle counter, memory-wait counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StRun;
            mc_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            resume_mc_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            resume_mc_q <= resume_mc_d;
            err_q       <= err_d;
        end
    end

    // Saturating stall and branch-flush performance counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (branch_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign state_o     = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign err_timeout = err_q;

    hazard_fwd_mux #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W)
    ) u_fwd_a (
        .enable      (reset),
        .src         (ex_rs),
        .rf_data     (ex_rdA),
        .mem_waddr   (mem_waddr),
        .mem_regwrite(mem_regwrite),
        .mem_memread (mem_memread),
        .mem_data    (mem_alu_out),
        .wb_waddr    (wb_waddr),
        .wb_regwrite (wb_regwrite),
        .wb_data     (wb_data),
        .sel         (fwd_a),
        .operand     (ex_opA)
    );

    hazard_fwd_mux #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W)
    ) u_fwd_b (
        .enable      (reset),
        .src         (ex_rt),
        .rf_data     (ex_rdB),
        .mem_waddr   (mem_waddr),
        .mem_regwrite(mem_regwrite),
        .mem_memread (mem_memread),
        .mem_data    (mem_alu_out),
        .wb_waddr    (wb_waddr),
        .wb_regwrite (wb_regwrite),
        .wb_data     (wb_data),
        .sel         (fwd_b),
        .operand     (ex_opB)
    );

    // A memory access and a taken branch in MEM at once cannot come from a legal program.
    assert property (@(posedge clock) disable iff (!reset) !(dmem_req && branch_taken));

endmodule
